// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the MIPS32 5-stage pipeline:
//   DATA_W / ADDR_W : datapath and byte-address widths
//   RESET_PC        : PC value loaded on reset
//   NOP_INST        : bubble instruction injected into IF/ID on a flush
//   OP_J / OP_JAL   : primary opcodes of the J-format jumps (decoded in ID)
//   word_align()    : clears the byte-offset bits of a redirect target
// -----------------------------------------------------------------------------
package cpu_defs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  // There is no misalignment exception: a redirect target is simply
  // truncated down to the containing word.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC priority mux for the fetch stage.
// Ports:
//   pc, pc_plus4                : current PC and its sequential successor
//   branch_taken, branch_target : redirect from EX (highest priority)
//   stall                       : load-use hazard from ID
//   jump, jump_target           : redirect from ID (loses to stall)
//   next_pc                     : PC value for the next edge
//   flush                       : replace the IF/ID contents with a bubble
//   hold                        : keep the IF/ID contents unchanged
// Reset is not handled here; the owning flops give it top priority.
// -----------------------------------------------------------------------------
module next_pc_sel
  import cpu_defs::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              flush,
  output logic              hold
);

  always_comb begin
    // NOTE: every output gets a default before the priority chain so no
    // path through the if/else leaves a value unassigned (no latch).
    next_pc = pc_plus4;
    flush   = 1'b0;
    hold    = 1'b0;
    if (branch_taken) begin
      // The instruction stalled in ID is squashed by EX anyway, so a taken
      // branch overrides a concurrent stall.
      next_pc = word_align(branch_target);
      flush   = 1'b1;
    end else if (stall) begin
      // A jump waiting in ID is re-presented once the stall clears.
      next_pc = pc;
      hold    = 1'b1;
    end else if (jump) begin
      // No delay slot: the instruction fetched behind the jump is dropped.
      next_pc = word_align(jump_target);
      flush   = 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM, and loads the IF/ID pipeline register.
// Parameters:
//   RESET_PC : PC value loaded on reset
//   NOP_INST : instruction injected into IF/ID on a flush
// Ports:
//   clk, reset        : clock; synchronous active-high reset
//   Stall             : hold PC and IF/ID (load-use hazard)
//   Jump, Jump_Target : jump resolved in ID
//   Branch_Taken,
//   Branch_Target     : taken branch resolved in EX
//   Inst_Addr         : ROM byte address (= PC)
//   Inst_In           : ROM data, valid in the same cycle
//   IF_ID_Inst        : registered instruction for ID
//   IF_ID_PC_Plus4    : registered PC+4 of that instruction
//   IF_ID_Valid       : IF_ID_Inst is a real fetched instruction
//   Fetch_Count       : number of instructions accepted into IF/ID
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic [31:0] Inst_Addr,
  input  logic [31:0] Inst_In,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] IF_ID_PC_Plus4,
  output logic        IF_ID_Valid,
  output logic [31:0] Fetch_Count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        flush;
  logic        hold;

  // Wraps modulo 2^32: 0xFFFFFFFC + 4 = 0.
  assign pc_plus4 = pc_q + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pc            (pc_q),
    .pc_plus4      (pc_plus4),
    .branch_taken  (Branch_Taken),
    .branch_target (Branch_Target),
    .stall         (Stall),
    .jump          (Jump),
    .jump_target   (Jump_Target),
    .next_pc       (pc_d),
    .flush         (flush),
    .hold          (hold)
  );

  always_comb begin
    inst_d     = inst_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (flush) begin
      inst_d     = NOP_INST;
      pc_plus4_d = 32'd0;
      valid_d    = 1'b0;
    end else if (!hold) begin
      // Normal capture is the only case that retires a fetch.
      inst_d     = Inst_In;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign Inst_Addr      = pc_q;
  assign IF_ID_Inst     = inst_q;
  assign IF_ID_PC_Plus4 = pc_plus4_q;
  assign IF_ID_Valid    = valid_q;
  assign Fetch_Count    = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage. A stimulus process applies one input
// vector per cycle and, after the edge it targets, queues the hand-computed
// stage state. A monitor process pops that state on the falling edge and
// compares every output.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] count;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic [31:0] Inst_Addr;
  logic [31:0] Inst_In;
  logic [31:0] IF_ID_Inst;
  logic [31:0] IF_ID_PC_Plus4;
  logic        IF_ID_Valid;
  logic [31:0] Fetch_Count;

  logic [31:0] rom [32];
  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Combinational ROM, zero-cycle fetch latency.
  assign Inst_In = rom[Inst_Addr[6:2]];

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .Stall          (Stall),
    .Jump           (Jump),
    .Jump_Target    (Jump_Target),
    .Branch_Taken   (Branch_Taken),
    .Branch_Target  (Branch_Target),
    .Inst_Addr      (Inst_Addr),
    .Inst_In        (Inst_In),
    .IF_ID_Inst     (IF_ID_Inst),
    .IF_ID_PC_Plus4 (IF_ID_PC_Plus4),
    .IF_ID_Valid    (IF_ID_Valid),
    .Fetch_Count    (Fetch_Count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the expected state is queued after the edge.
  task automatic step(input logic rst, input logic stl, input logic jmp, input logic [31:0] jt,
                      input logic br, input logic [31:0] bt,
                      input logic [31:0] e_addr, input logic [31:0] e_inst,
                      input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_count);
    exp_t e;
    reset         = rst;
    Stall         = stl;
    Jump          = jmp;
    Jump_Target   = jt;
    Branch_Taken  = br;
    Branch_Target = bt;
    @(posedge clk);
    e.addr  = e_addr;
    e.inst  = e_inst;
    e.pc4   = e_pc4;
    e.valid = e_valid;
    e.count = e_count;
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("inst_addr",   Inst_Addr,        e.addr);
        check("if_id_inst",  IF_ID_Inst,       e.inst);
        check("if_id_pc4",   IF_ID_PC_Plus4,   e.pc4);
        check("if_id_valid", {31'd0, IF_ID_Valid}, {31'd0, e.valid});
        check("fetch_count", Fetch_Count,      e.count);
      end
    end
  end

  // Stimulus
  initial begin
    int budget;
    for (int k = 0; k < 32; k++) rom[k] = 32'h2000_0000 | k;
    rom[0]  = 32'h8c08_0000;
    rom[1]  = 32'h8c09_0004;
    rom[2]  = 32'h8c0a_0008;
    rom[3]  = 32'h8c0b_000c;
    rom[4]  = 32'h8c0c_0010;
    rom[8]  = 32'h010c_802d;
    rom[26] = 32'h0810_001a;   // j 0x1a : self-loop halt at 0x68

    //   rst stl jmp jt            br  bt             addr          inst          pc4           v  count
    step(1, 0, 0, 32'h0,        0, 32'h0,        32'h00,       32'h0,        32'h0,        0, 0);  // reset
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h04,       32'h8c080000, 32'h04,       1, 1);
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h08,       32'h8c090004, 32'h08,       1, 2);
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h0C,       32'h8c0a0008, 32'h0C,       1, 3);
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'h8c0b000c, 32'h10,       1, 4);
    step(0, 1, 0, 32'h0,        0, 32'h0,        32'h10,       32'h8c0b000c, 32'h10,       1, 4);  // stall
    step(0, 1, 0, 32'h0,        0, 32'h0,        32'h10,       32'h8c0b000c, 32'h10,       1, 4);  // stall
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h14,       32'h8c0c0010, 32'h14,       1, 5);  // release
    step(0, 1, 0, 32'h0,        1, 32'h20,       32'h20,       32'h0,        32'h0,        0, 5);  // branch beats stall
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h24,       32'h010c802d, 32'h24,       1, 6);
    step(0, 1, 1, 32'h40,       0, 32'h0,        32'h24,       32'h010c802d, 32'h24,       1, 6);  // stall beats jump
    step(0, 0, 1, 32'h40,       0, 32'h0,        32'h40,       32'h0,        32'h0,        0, 6);  // jump re-presented
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h44,       32'h20000010, 32'h44,       1, 7);
    step(0, 0, 1, 32'h68,       0, 32'h0,        32'h68,       32'h0,        32'h0,        0, 7);  // j 0x1a
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h6C,       32'h0810001a, 32'h6C,       1, 8);
    step(0, 0, 1, 32'h6B,       0, 32'h0,        32'h68,       32'h0,        32'h0,        0, 8);  // unaligned target
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h6C,       32'h0810001a, 32'h6C,       1, 9);
    step(0, 0, 1, 32'h68,       0, 32'h0,        32'h68,       32'h0,        32'h0,        0, 9);
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h6C,       32'h0810001a, 32'h6C,       1, 10);
    step(0, 0, 1, 32'h68,       1, 32'h31,       32'h30,       32'h0,        32'h0,        0, 10); // branch beats jump
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h34,       32'h2000000C, 32'h34,       1, 11);
    step(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        32'hFFFFFFFC, 32'h0,        32'h0,        0, 11);
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h00,       32'h2000001F, 32'h00,       1, 12); // PC+4 wraps
    step(0, 0, 1, 32'h50,       0, 32'h0,        32'h50,       32'h0,        32'h0,        0, 12);
    step(1, 1, 1, 32'h68,       0, 32'h0,        32'h00,       32'h0,        32'h0,        0, 0);  // reset wins
    step(0, 0, 0, 32'h0,        0, 32'h0,        32'h04,       32'h8c080000, 32'h04,       1, 1);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
